// File: rtl/angle_pkg.sv
// Shared types and constants for the degree-to-radian converter.
package angle_pkg;

    typedef enum logic [1:0] {
        ANG_DIRECT = 2'd0,
        ANG_WRAP_U = 2'd1,
        ANG_WRAP_S = 2'd2
    } ang_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_FIX,
        ST_MUL,
        ST_HOLD
    } ang_state_e;

    localparam int DEG_FULL = 360;
    localparam int DEG_HALF = 180;

    // Rounded pi/180 scaled by 2^frac_bits; evaluated at elaboration only.
    function automatic int deg2rad_fx(input int frac_bits);
        real k;
        k = (3.14159265358979323846 / 180.0) * (2.0 ** frac_bits);
        return $rtoi(k + 0.5);
    endfunction

endpackage

// File: rtl/mod360_step.sv
// One restoring-subtract step of the modulo-360 reduction: r' = r mod-step (360 << k).
module mod360_step
    import angle_pkg::*;
#(
    parameter int IN_BITS = 16,
    parameter int KW      = 3
) (
    input  logic [IN_BITS-1:0] r,
    input  logic [KW-1:0]      k,
    output logic [IN_BITS-1:0] r_next
);

    logic [IN_BITS-1:0] sub;

    // 360 << (IN_BITS-9) still fits in IN_BITS unsigned bits.
    assign sub    = IN_BITS'(DEG_FULL) << k;
    assign r_next = (r >= sub) ? r - sub : r;

endmodule

// File: rtl/angle_wrap_to_radians.sv
// Multi-cycle signed degrees -> fixed-point radians, with optional wrap to [0,360) or [-180,180).
module angle_wrap_to_radians
    import angle_pkg::*;
#(
    parameter int IN_BITS   = 16,
    parameter int FRAC_BITS = 16,
    parameter int OUT_BITS  = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_BITS-1:0]  in_deg,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_BITS-1:0] out_rad,
    output logic signed [IN_BITS-1:0]  out_deg
);

    localparam int NSTEP = IN_BITS - 8;
    localparam int KW    = $clog2(NSTEP);
    localparam logic [KW-1:0] K_TOP = KW'(IN_BITS - 9);
    localparam logic signed [OUT_BITS-1:0] K_FX = OUT_BITS'(deg2rad_fx(FRAC_BITS));

    if (IN_BITS < 10) begin : g_bad_in_bits
        $error("angle_wrap_to_radians: IN_BITS must be >= 10");
    end
    if (OUT_BITS < IN_BITS + FRAC_BITS + 2) begin : g_bad_out_bits
        $error("angle_wrap_to_radians: OUT_BITS must be >= IN_BITS+FRAC_BITS+2");
    end

    ang_state_e                 state;
    ang_mode_e                  mode;
    logic                       neg;
    logic [IN_BITS-1:0]         r;
    logic [KW-1:0]              k;
    logic signed [IN_BITS-1:0]  d;

    logic [IN_BITS-1:0]         r_step;
    logic [IN_BITS-1:0]         r_fix;
    logic signed [IN_BITS-1:0]  d_fix;
    logic signed [OUT_BITS-1:0] d_ext;
    logic signed [OUT_BITS-1:0] prod;

    mod360_step #(
        .IN_BITS (IN_BITS),
        .KW      (KW)
    ) u_step (
        .r      (r),
        .k      (k),
        .r_next (r_step)
    );

    // r is already in [0,359] here, so 360-r and r-360 both stay in range.
    always_comb begin
        r_fix = r;
        if (neg && (r != '0))
            r_fix = IN_BITS'(DEG_FULL) - r;
        d_fix = $signed(r_fix);
        if ((mode == ANG_WRAP_S) && (r_fix >= IN_BITS'(DEG_HALF)))
            d_fix = $signed(r_fix - IN_BITS'(DEG_FULL));
    end

    assign d_ext = {{(OUT_BITS-IN_BITS){d[IN_BITS-1]}}, d};
    assign prod  = d_ext * K_FX;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode      <= ANG_DIRECT;
            neg       <= 1'b0;
            r         <= '0;
            k         <= '0;
            d         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rad   <= '0;
            out_deg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        neg      <= in_deg[IN_BITS-1];
                        // Magnitude kept unsigned so the most negative input is exact.
                        r        <= $unsigned(in_deg[IN_BITS-1] ? -in_deg : in_deg);
                        d        <= in_deg;
                        k        <= K_TOP;
                        case (in_mode)
                            2'd1: begin
                                mode  <= ANG_WRAP_U;
                                state <= ST_REDUCE;
                            end
                            2'd2: begin
                                mode  <= ANG_WRAP_S;
                                state <= ST_REDUCE;
                            end
                            default: begin
                                mode  <= ANG_DIRECT;
                                state <= ST_MUL;
                            end
                        endcase
                    end
                end
                ST_REDUCE: begin
                    r <= r_step;
                    if (k == '0)
                        state <= ST_FIX;
                    else
                        k <= k - KW'(1);
                end
                ST_FIX: begin
                    d     <= d_fix;
                    state <= ST_MUL;
                end
                ST_MUL: begin
                    out_rad <= prod;
                    out_deg <= d;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_wrap_to_radians.sv
// Scoreboard bench for angle_wrap_to_radians: driver pushes expectations, monitor pops on output.
module tb_angle_wrap_to_radians;

    localparam int IN_BITS   = 16;
    localparam int FRAC_BITS = 16;
    localparam int OUT_BITS  = 40;
    localparam int LAT_WRAP  = IN_BITS - 8 + 3;
    localparam int LAT_DIR   = 2;
    localparam longint KFX   = 1144;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_BITS-1:0]  in_deg;
    logic [1:0]                 in_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUT_BITS-1:0] out_rad;
    logic signed [IN_BITS-1:0]  out_deg;

    angle_wrap_to_radians #(
        .IN_BITS   (IN_BITS),
        .FRAC_BITS (FRAC_BITS),
        .OUT_BITS  (OUT_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_deg    (in_deg),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rad   (out_rad),
        .out_deg   (out_deg)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint rad;
        int     deg;
        int     acc;
        int     lat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rmode    = 1;   // 0 random out_ready, 1 always ready, 2 stall

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: modular arithmetic straight from the wrap rules.
    function automatic int ref_deg(input int mode, input int x);
        int m;
        m = ((x % 360) + 360) % 360;
        case (mode)
            1: return m;
            2: return (m >= 180) ? m - 360 : m;
            default: return x;
        endcase
    endfunction

    task automatic send(input int mode, input int x, input bit track);
        exp_t e;
        int   n;
        logic [31:0] xv;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        xv       = x;
        in_valid = 1'b1;
        in_mode  = 2'(mode);
        in_deg   = xv[IN_BITS-1:0];
        if (track) begin
            e.deg = ref_deg(mode, x);
            e.rad = longint'(e.deg) * KFX;
            e.acc = cyc + 1;
            e.lat = (mode == 1 || mode == 2) ? LAT_WRAP : LAT_DIR;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: compares on first sight of out_valid, checks stability while held, picks out_ready.
    initial begin
        bit   seen;
        bit   have;
        bit   rdy;
        exp_t cur;
        seen      = 1'b0;
        have      = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 1'b0;
                have      = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (out_valid) begin
                chk("in_ready_low_in_hold", in_ready, 0);
                if (!seen) begin
                    seen = 1'b1;
                    if (q.size() == 0) begin
                        have = 1'b0;
                        chk("unexpected_output", 1, 0);
                    end else begin
                        have = 1'b1;
                        cur  = q[0];
                        chk("out_rad", $signed(out_rad), cur.rad);
                        chk("out_deg", $signed(out_deg), cur.deg);
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end else if (have) begin
                    chk("out_rad_stable", $signed(out_rad), cur.rad);
                    chk("out_deg_stable", $signed(out_deg), cur.deg);
                end
            end
            case (rmode)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = 1'b1;
                default: rdy = 1'b0;
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (have) void'(q.pop_front());
                seen = 1'b0;
                have = 1'b0;
            end
        end
    end

    int dmode[15] = '{1, 1, 2, 2, 2, 1, 0, 0, 1, 2, 1, 2, 2, 3, 0};
    int ddeg[15]  = '{90, -90, -90, 540, 360, -32768, -32768, 0, 0, 0, 360, -180, 180, 100, 32767};
    int bnd[10]   = '{0, 180, -180, 360, -360, 359, -1, 32767, -32768, 720};

    initial begin
        int n;
        int vcnt;
        int mode;
        int deg;
        int sel;
        logic [15:0] rv;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 2'd0;
        in_deg   = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_rad", $signed(out_rad), 0);
        chk("reset_out_deg", $signed(out_deg), 0);
        rst_n = 1'b1;
        @(negedge clk);

        rmode = 1;
        for (int i = 0; i < 15; i++) send(dmode[i], ddeg[i], 1'b1);
        drain(100);

        // Backpressure: hold result, offer a request that must be ignored.
        rmode = 2;
        send(1, 90, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'd0;
            in_deg   = 16'sd7;
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid_held", out_valid, 1);
        end
        in_valid = 1'b0;
        rmode    = 1;
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_released", out_valid, 0);
        chk("bp_in_ready_after", in_ready, 1);
        drain(20);

        // Reset during REDUCE must discard the request.
        send(1, 1000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("abort_no_valid", vcnt, 0);
        chk("abort_in_ready", in_ready, 1);

        rmode = 0;
        for (int i = 0; i < 1000; i++) begin
            mode = $urandom_range(0, 3);
            sel  = $urandom_range(0, 3);
            case (sel)
                0: begin
                    rv  = 16'($urandom);
                    deg = int'($signed(rv));
                end
                1:       deg = int'($urandom_range(0, 1440)) - 720;
                2:       deg = bnd[$urandom_range(0, 9)];
                default: deg = int'($urandom_range(0, 359));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(mode, deg, 1'b1);
        end
        drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
